// File: rtl/cache_port_arbiter.sv
// Two-port (instruction fetch / data load-store) arbiter in front of a single-ported cache.
// Optional macro ARB_DPRIO_EN: data side wins every conflict instead of round-robin.
module cache_port_arbiter #(
   parameter int WDOG_W = 8
) (
   input  logic        CPU_CLK,
   input  logic        RST,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_ack,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic [31:0] d_addr,
   input  logic        d_we,
   input  logic [31:0] d_wdata,
   input  logic        d_force_miss,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic [31:0] cache_precycle_addr,
   output logic        cache_precycle_we,
   output logic        cache_precycle_enable,
   output logic        cache_precycle_force_miss,
   output logic [31:0] cache_datao,
   input  logic [31:0] cache_datai,
   input  logic        cache_busy,
   output logic        arb_timeout,
   output logic        last_grant
);

   // state | meaning
   // IDLE  | no access in flight; sample requests, issue when cache not busy
   // LOOK  | cache tag lookup cycle after issue
   // CHECK | first result cycle; complete on hit, else wait
   // WAIT  | miss in progress; watchdog counting
   typedef enum logic [1:0] {IDLE, LOOK, CHECK, WAIT} state_t;

   state_t              state_q, state_d;
   logic                gnt_q, gnt_d;
   logic                last_q, last_d;
   logic                tmo_q, tmo_d;
   logic                i_ack_q, i_ack_d;
   logic                d_ack_q, d_ack_d;
   logic [31:0]         i_rdata_q, i_rdata_d;
   logic [31:0]         d_rdata_q, d_rdata_d;
   logic [WDOG_W-1:0]   wdog_q, wdog_d;
   logic [WDOG_W-1:0]   wdog_inc;
   logic                pick_d;
   logic                complete;
   logic [31:0]         cpl_data;
   logic                pc_en;

`ifdef ARB_DPRIO_EN
   assign pick_d = d_req;
`else
   assign pick_d = d_req & (~i_req | ~last_q);
`endif

   assign wdog_inc = wdog_q + WDOG_W'(1);

   always_comb begin
      state_d                   = state_q;
      gnt_d                     = gnt_q;
      last_d                    = last_q;
      tmo_d                     = tmo_q;
      wdog_d                    = '0;
      i_ack_d                   = 1'b0;
      d_ack_d                   = 1'b0;
      i_rdata_d                 = i_rdata_q;
      d_rdata_d                 = d_rdata_q;
      cache_precycle_addr       = '0;
      cache_precycle_we         = 1'b0;
      cache_precycle_force_miss = 1'b0;
      cache_datao               = '0;
      pc_en                     = 1'b0;
      complete                  = 1'b0;
      cpl_data                  = cache_datai;
      case (state_q)
         IDLE: begin
            if (!cache_busy && (i_req || d_req)) begin
               pc_en   = 1'b1;
               gnt_d   = pick_d;
               last_d  = pick_d;
               state_d = LOOK;
               if (pick_d) begin
                  cache_precycle_addr       = d_addr;
                  cache_precycle_we         = d_we;
                  cache_precycle_force_miss = d_force_miss;
                  cache_datao               = d_wdata;
               end else begin
                  cache_precycle_addr = i_addr;
               end
            end
         end
         LOOK:  state_d = CHECK;
         CHECK: begin
            if (cache_busy) state_d = WAIT;
            else            complete = 1'b1;
         end
         WAIT: begin
            if (!cache_busy) begin
               complete = 1'b1;
            end else if (wdog_inc == '1) begin
               // cache never answered: release the requester with a poison value
               complete = 1'b1;
               cpl_data = 32'hFFFF_FFFF;
               tmo_d    = 1'b1;
            end else begin
               wdog_d = wdog_inc;
            end
         end
         default: state_d = IDLE;
      endcase
      if (complete) begin
         state_d = IDLE;
         if (gnt_q) begin
            d_ack_d   = 1'b1;
            d_rdata_d = cpl_data;
         end else begin
            i_ack_d   = 1'b1;
            i_rdata_d = cpl_data;
         end
      end
   end

   always_ff @(posedge CPU_CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         gnt_q     <= 1'b0;
         last_q    <= 1'b1;
         tmo_q     <= 1'b0;
         wdog_q    <= '0;
         i_ack_q   <= 1'b0;
         d_ack_q   <= 1'b0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         last_q    <= last_d;
         tmo_q     <= tmo_d;
         wdog_q    <= wdog_d;
         i_ack_q   <= i_ack_d;
         d_ack_q   <= d_ack_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   assign cache_precycle_enable = pc_en & ~RST;
   assign i_ack       = i_ack_q;
   assign d_ack       = d_ack_q;
   assign i_rdata     = i_rdata_q;
   assign d_rdata     = d_rdata_q;
   assign arb_timeout = tmo_q;
   assign last_grant  = last_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter: issue-cycle vector table plus multi-cycle sequences.
module tb_cache_port_arbiter;

   localparam logic [31:0] I_ADDR = 32'h0000_1000;
   localparam logic [31:0] D_ADDR = 32'h0000_2000;
   localparam logic [31:0] D_WDAT = 32'h1234_5678;

   logic        CPU_CLK, RST;
   logic        i_req, i_ack, d_req, d_we, d_force_miss, d_ack;
   logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
   logic [31:0] cache_precycle_addr, cache_datao, cache_datai;
   logic        cache_precycle_we, cache_precycle_enable, cache_precycle_force_miss;
   logic        cache_busy, arb_timeout, last_grant;

   cache_port_arbiter #(.WDOG_W(4)) dut (
      .CPU_CLK(CPU_CLK), .RST(RST),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
      .d_force_miss(d_force_miss), .d_ack(d_ack), .d_rdata(d_rdata),
      .cache_precycle_addr(cache_precycle_addr), .cache_precycle_we(cache_precycle_we),
      .cache_precycle_enable(cache_precycle_enable),
      .cache_precycle_force_miss(cache_precycle_force_miss),
      .cache_datao(cache_datao), .cache_datai(cache_datai), .cache_busy(cache_busy),
      .arb_timeout(arb_timeout), .last_grant(last_grant)
   );

   initial CPU_CLK = 1'b0;
   always #5 CPU_CLK = ~CPU_CLK;

   typedef struct {
      logic        ir, dr, dwe, dfm, busy;
      logic        en;
      logic [31:0] addr;
      logic        we, fm, dside;
      logic        lg;
   } vec_t;

   vec_t vt[7];
   int n_vec = 0;
   int n_bad = 0;
   logic [31:0] cap_addr, cap_datao;
   logic        cap_we, cap_fm;
   logic        other_seen;

`ifdef ARB_DPRIO_EN
   localparam bit DPRIO = 1'b1;
`else
   localparam bit DPRIO = 1'b0;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      RST = 1'b1; i_req = 1'b0; d_req = 1'b0; cache_busy = 1'b0;
      repeat (2) begin @(posedge CPU_CLK); #1; end
      RST = 1'b0;
   endtask

   // Runs one access from cycle 0 (caller already raised the request); busy is high in
   // cycles bf..bt. Returns ack cycle (or -1) and first cycle enable was high (or -1).
   task automatic access(input bit side, input int bf, input int bt, input int maxc,
                         output int lat, output int first_en);
      lat = -1; first_en = -1; other_seen = 1'b0;
      cache_busy = (0 >= bf) && (0 <= bt);
      for (int c = 0; c <= maxc; c++) begin
         @(negedge CPU_CLK);
         if (first_en < 0 && cache_precycle_enable) begin
            first_en  = c;
            cap_addr  = cache_precycle_addr;
            cap_we    = cache_precycle_we;
            cap_fm    = cache_precycle_force_miss;
            cap_datao = cache_datao;
         end
         if (side ? i_ack : d_ack) other_seen = 1'b1;
         if (side ? d_ack : i_ack) begin
            lat = c;
            if (side) d_req = 1'b0; else i_req = 1'b0;
            break;
         end
         @(posedge CPU_CLK); #1;
         cache_busy = ((c + 1) >= bf) && ((c + 1) <= bt);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int lat, fe, cyc, both;
      logic got, exp_g;

      // conflict winner from a fresh reset (last_grant=1)
      exp_g = DPRIO ? 1'b1 : 1'b0;
      //        ir    dr    dwe   dfm   busy  en    addr    we    fm    dside lg
      vt[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, I_ADDR, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, D_ADDR, 1'b0, 1'b0, 1'b1, 1'b1};
      vt[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, D_ADDR, 1'b1, 1'b1, 1'b1, 1'b1};
      vt[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, exp_g ? D_ADDR : I_ADDR,
                exp_g, exp_g, exp_g, exp_g};
      vt[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1};
      vt[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1};
      vt[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1};

      i_addr = I_ADDR; d_addr = D_ADDR; d_wdata = D_WDAT; d_we = 1'b0;
      d_force_miss = 1'b0; cache_datai = 32'hCAFE_0001;
      do_reset();

      @(negedge CPU_CLK);
      chk("rst_i_ack", i_ack, 0);
      chk("rst_d_ack", d_ack, 0);
      chk("rst_i_rdata", i_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      chk("rst_last_grant", last_grant, 1);
      chk("rst_timeout", arb_timeout, 0);
      chk("rst_enable", cache_precycle_enable, 0);

      for (int k = 0; k < 7; k++) begin
         do_reset();
         i_req = vt[k].ir; d_req = vt[k].dr; d_we = vt[k].dwe;
         d_force_miss = vt[k].dfm; cache_busy = vt[k].busy;
         @(negedge CPU_CLK);
         chk($sformatf("v%0d_enable", k), cache_precycle_enable, vt[k].en);
         if (vt[k].en) begin
            chk($sformatf("v%0d_addr", k), cache_precycle_addr, vt[k].addr);
            chk($sformatf("v%0d_we", k), cache_precycle_we, vt[k].we);
            chk($sformatf("v%0d_fm", k), cache_precycle_force_miss, vt[k].fm);
            if (vt[k].dside) chk($sformatf("v%0d_datao", k), cache_datao, D_WDAT);
         end
         @(posedge CPU_CLK); #1;
         chk($sformatf("v%0d_last_grant", k), last_grant, vt[k].lg);
         i_req = 1'b0; d_req = 1'b0;
      end
      d_we = 1'b0; d_force_miss = 1'b0;

      // hit read on I side: 3-cycle latency
      do_reset();
      cache_datai = 32'hCAFE_0001; i_req = 1'b1;
      access(1'b0, -1, -1, 10, lat, fe);
      chk("hit_en_cycle", fe, 0);
      chk("hit_addr", cap_addr, I_ADDR);
      chk("hit_latency", lat, 3);
      chk("hit_rdata", i_rdata, 32'hCAFE_0001);
      chk("hit_no_d_ack", other_seen, 0);
      @(posedge CPU_CLK); #1;

      // D write with miss: busy cycles 2..9
      cache_datai = 32'hBEEF_0002; d_we = 1'b1; d_req = 1'b1;
      access(1'b1, 2, 9, 20, lat, fe);
      chk("wr_en_cycle", fe, 0);
      chk("wr_we", cap_we, 1);
      chk("wr_datao", cap_datao, D_WDAT);
      chk("wr_latency", lat, 11);
      chk("wr_d_rdata", d_rdata, 32'hBEEF_0002);
      chk("wr_i_rdata_hold", i_rdata, 32'hCAFE_0001);
      @(posedge CPU_CLK); #1;
      d_we = 1'b0; cache_busy = 1'b0;

      // both sides held: back-to-back grants
      do_reset();
      i_req = 1'b1; d_req = 1'b1; cyc = 0; both = 0;
      for (int n = 0; n < 4; n++) begin
         got = 1'b0;
         for (int k = 0; k < 10 && !got; k++) begin
            @(negedge CPU_CLK);
            if (i_ack && d_ack) both++;
            if (i_ack || d_ack) begin
               got = 1'b1;
               chk($sformatf("rr_grant%0d", n), d_ack, DPRIO ? 1'b1 : 1'(n % 2));
               chk($sformatf("rr_cycle%0d", n), cyc, 3 * (n + 1));
               chk($sformatf("rr_last_grant%0d", n), last_grant, d_ack);
               if (n == 3) begin i_req = 1'b0; d_req = 1'b0; end
            end
            @(posedge CPU_CLK); #1;
            cyc++;
         end
         chk($sformatf("rr_ack_seen%0d", n), got, 1);
      end
      @(negedge CPU_CLK);
      chk("rr_ack_one_cycle", i_ack | d_ack, 0);
      chk("rr_never_both", both, 0);

      // watchdog: busy stuck high after issue
      do_reset();
      i_req = 1'b1;
      access(1'b0, 1, 1000, 40, lat, fe);
      chk("wdog_latency", lat, 18);
      chk("wdog_rdata", i_rdata, 32'hFFFF_FFFF);
      chk("wdog_timeout", arb_timeout, 1);
      @(posedge CPU_CLK); #1;
      cache_datai = 32'h1111_0003; i_req = 1'b1;
      access(1'b0, -1, -1, 10, lat, fe);
      chk("wdog_next_latency", lat, 3);
      chk("wdog_next_rdata", i_rdata, 32'h1111_0003);
      chk("wdog_sticky", arb_timeout, 1);
      @(posedge CPU_CLK); #1;
      do_reset();
      @(negedge CPU_CLK);
      chk("wdog_cleared_by_rst", arb_timeout, 0);
      @(posedge CPU_CLK); #1;

      // RST while waiting on a miss
      do_reset();
      d_req = 1'b1; cache_busy = 1'b0; other_seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge CPU_CLK);
         if (d_ack || i_ack) other_seen = 1'b1;
         @(posedge CPU_CLK); #1;
         cache_busy = 1'b1;
      end
      RST = 1'b1; d_req = 1'b0; i_req = 1'b1; cache_busy = 1'b0;
      @(negedge CPU_CLK);
      chk("rstwait_enable", cache_precycle_enable, 0);
      chk("rstwait_no_ack", other_seen | d_ack | i_ack, 0);
      @(posedge CPU_CLK); #1;
      RST = 1'b0; cache_datai = 32'h2222_0004;
      access(1'b0, -1, -1, 10, lat, fe);
      chk("rstwait_next_en", fe, 0);
      chk("rstwait_next_latency", lat, 3);
      chk("rstwait_next_rdata", i_rdata, 32'h2222_0004);
      chk("rstwait_no_d_ack", other_seen, 0);
      chk("rstwait_d_rdata", d_rdata, 0);
      @(posedge CPU_CLK); #1;

      // cache busy in IDLE holds off issue
      do_reset();
      i_req = 1'b1;
      access(1'b0, 0, 4, 20, lat, fe);
      chk("busyidle_en_cycle", fe, 5);
      chk("busyidle_latency", lat, 8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
